uart_rx_buffer: RTL and testbench

Receive-side buffer sitting directly downstream of the UART receiver. It completes the receiver's interrupt/acknowledge handshake on the system clock, captures each received byte and its error flags into a first-word-fall-through FIFO, and exposes a simple pop interface to the host logic. It decouples host read latency from line timing so that back-to-back frames are not lost while the host is busy.

---
 rtl/uart_rx_buffer.sv | 159 +++++++++++++++
 tb/tb_uart_rx_buffer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_buffer.sv
// UART receive buffer: interrupt/acknowledge handshake plus FWFT FIFO.
// Define UART_RX_BUFFER_ERROR_STORE_EN to keep receiver error flags per entry.
module uart_rx_buffer #(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [7:0]            RxData,
    input  logic [2:0]            RxErrors,
    input  logic                  RxInterrupt,
    output logic                  RxAcknowledge,
    input  logic                  ReadEnable,
    output logic [7:0]            ReadData,
    output logic [2:0]            ReadErrors,
    output logic                  Empty,
    output logic                  Full,
    output logic [ADDR_WIDTH:0]   Count,
    output logic                  Overflow,
    input  logic                  ClearOverflow
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

`ifdef UART_RX_BUFFER_ERROR_STORE_EN
    localparam int EW = 11;
`else
    localparam int EW = 8;
`endif

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_e;

    state_e state_q, state_d;

    logic sync1_q, sync2_q;

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  ovf_q, ovf_d;

    logic          wr_req;
    logic          wr_acc;
    logic          pop;
    logic          drop;
    logic [EW-1:0] wr_entry;
    logic [EW-1:0] rd_entry;
    logic [EW-1:0] mem [DEPTH];

    // RxInterrupt comes from another clock domain.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= RxInterrupt;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (sync2_q)  state_d = ACK;
            ACK:  if (!sync2_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        RxAcknowledge = (state_q == ACK);
        wr_req        = (state_q == IDLE) && sync2_q;
    end

    always_comb begin
        Empty  = (count_q == '0);
        Full   = (count_q == FULL_CNT);
        Count  = count_q;
        Overflow = ovf_q;
    end

    // A pop frees the slot in the same edge, so a full FIFO still accepts.
    always_comb begin
        pop    = ReadEnable && !Empty;
        wr_acc = wr_req && (!Full || pop);
        drop   = wr_req && Full && !pop;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({wr_acc, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        ovf_d = ovf_q;
        unique case (1'b1)
            drop:          ovf_d = 1'b1;
            ClearOverflow: ovf_d = 1'b0;
            default:       ovf_d = ovf_q;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge Clock) begin
        if (wr_acc) begin
            mem[wr_ptr_q] <= wr_entry;
        end
    end

    assign rd_entry = mem[rd_ptr_q];
    assign ReadData = rd_entry[7:0];

`ifdef UART_RX_BUFFER_ERROR_STORE_EN
    assign wr_entry   = {RxErrors, RxData};
    assign ReadErrors = rd_entry[10:8];
`else
    logic [2:0] unused_rx_errors;
    assign unused_rx_errors = RxErrors;
    assign wr_entry   = RxData;
    assign ReadErrors = 3'b000;
`endif

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Bench for uart_rx_buffer: vector table, directed corners,
// and randomized traffic against a queue-based reference model.
module tb_uart_rx_buffer;

    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          Clock = 1'b0;
    logic          Reset = 1'b0;
    logic [7:0]    RxData = '0;
    logic [2:0]    RxErrors = '0;
    logic          RxInterrupt = 1'b0;
    logic          RxAcknowledge;
    logic          ReadEnable = 1'b0;
    logic [7:0]    ReadData;
    logic [2:0]    ReadErrors;
    logic          Empty;
    logic          Full;
    logic [AW:0]   Count;
    logic          Overflow;
    logic          ClearOverflow = 1'b0;

    int total = 0;
    int bad   = 0;

    logic [10:0] mq[$];
    bit          movf = 1'b0;

    uart_rx_buffer #(.ADDR_WIDTH(AW)) dut (
        .Clock(Clock),
        .Reset(Reset),
        .RxData(RxData),
        .RxErrors(RxErrors),
        .RxInterrupt(RxInterrupt),
        .RxAcknowledge(RxAcknowledge),
        .ReadEnable(ReadEnable),
        .ReadData(ReadData),
        .ReadErrors(ReadErrors),
        .Empty(Empty),
        .Full(Full),
        .Count(Count),
        .Overflow(Overflow),
        .ClearOverflow(ClearOverflow)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        bit         irq;
        bit         rd;
        bit         ack;
        int         cnt;
        bit         empty;
        bit         chk_data;
        logic [7:0] data;
    } vec_t;

    vec_t vt[8];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] exp_err(input logic [10:0] e);
`ifdef UART_RX_BUFFER_ERROR_STORE_EN
        return e[10:8];
`else
        return 3'b000;
`endif
    endfunction

    task automatic check_state(input string tag);
        chk({tag, " count"}, 32'(Count), 32'(mq.size()));
        chk({tag, " empty"}, 32'(Empty), 32'(mq.size() == 0));
        chk({tag, " full"}, 32'(Full), 32'(mq.size() == DEPTH));
        chk({tag, " ovf"}, 32'(Overflow), 32'(movf));
        if (mq.size() > 0) begin
            chk({tag, " data"}, 32'(ReadData), 32'(mq[0][7:0]));
            chk({tag, " err"}, 32'(ReadErrors), 32'(exp_err(mq[0])));
        end
    endtask

    // One clock edge: model applies pop first, then the optional write.
    task automatic edge_step(input bit wr, input bit rd, input bit clr,
                             input string tag);
        bit pop;
        bit dropped;
        ReadEnable    = rd;
        ClearOverflow = clr;
        pop     = rd && (mq.size() > 0);
        dropped = wr && (mq.size() == DEPTH) && !pop;
        @(posedge Clock);
        #1;
        if (pop) void'(mq.pop_front());
        if (wr && !dropped) mq.push_back({RxErrors, RxData});
        if (dropped) movf = 1'b1;
        else if (clr) movf = 1'b0;
        ReadEnable    = 1'b0;
        ClearOverflow = 1'b0;
        check_state(tag);
    endtask

    // mode: 0 no reads, 1 read on the write edge, 2 random 1/2, 3 random 1/8
    task automatic send_byte(input logic [7:0] d, input logic [2:0] e,
                             input int mode);
        bit rd;
        RxData      = d;
        RxErrors    = e;
        RxInterrupt = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) RxInterrupt = 1'b0;
            unique case (mode)
                1:       rd = (i == 2);
                2:       rd = $urandom_range(0, 1) == 1;
                3:       rd = $urandom_range(0, 7) == 0;
                default: rd = 1'b0;
            endcase
            edge_step(i == 2, rd, 1'b0, "send");
            chk("ack", 32'(RxAcknowledge), 32'(i >= 2 && i <= 4));
        end
    endtask

    initial begin
        vt[0] = '{1, 0, 0, 0, 1, 0, 8'h00};
        vt[1] = '{1, 0, 0, 0, 1, 0, 8'h00};
        vt[2] = '{1, 0, 1, 1, 0, 1, 8'hA5};
        vt[3] = '{0, 0, 1, 1, 0, 1, 8'hA5};
        vt[4] = '{0, 0, 1, 1, 0, 1, 8'hA5};
        vt[5] = '{0, 0, 0, 1, 0, 1, 8'hA5};
        vt[6] = '{0, 1, 0, 0, 1, 0, 8'h00};
        vt[7] = '{0, 1, 0, 0, 1, 0, 8'h00};

        repeat (2) @(posedge Clock);
        #1;
        chk("rst ack", 32'(RxAcknowledge), 0);
        chk("rst empty", 32'(Empty), 1);
        Reset = 1'b1;
        check_state("reset");

        // single byte, cycle by cycle
        RxData   = 8'hA5;
        RxErrors = 3'b000;
        for (int i = 0; i < 8; i++) begin
            RxInterrupt = vt[i].irq;
            ReadEnable  = vt[i].rd;
            @(posedge Clock);
            #1;
            ReadEnable = 1'b0;
            chk($sformatf("vec%0d ack", i), 32'(RxAcknowledge), 32'(vt[i].ack));
            chk($sformatf("vec%0d cnt", i), 32'(Count), 32'(vt[i].cnt));
            chk($sformatf("vec%0d empty", i), 32'(Empty), 32'(vt[i].empty));
            if (vt[i].chk_data)
                chk($sformatf("vec%0d data", i), 32'(ReadData), 32'(vt[i].data));
        end

        // fill, then overflow drop
        for (int i = 0; i < DEPTH; i++) send_byte(8'(i), 3'(i), 0);
        chk("fill full", 32'(Full), 1);
        chk("fill cnt", 32'(Count), 16);
        send_byte(8'hFF, 3'b111, 0);
        chk("drop ovf", 32'(Overflow), 1);
        chk("drop cnt", 32'(Count), 16);
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain order", 32'(ReadData), 32'(i));
            edge_step(1'b0, 1'b1, 1'b0, "drain");
        end
        edge_step(1'b0, 1'b0, 1'b1, "clrovf");
        chk("ovf cleared", 32'(Overflow), 0);

        // full FIFO with a pop on the write edge
        for (int i = 0; i < DEPTH; i++) send_byte(8'h40 + 8'(i), 3'b010, 0);
        send_byte(8'hEE, 3'b001, 1);
        chk("fullpop cnt", 32'(Count), 16);
        chk("fullpop ovf", 32'(Overflow), 0);
        while (mq.size() > 1) edge_step(1'b0, 1'b1, 1'b0, "drain2");
        chk("fullpop last", 32'(ReadData), 32'h0EE);
        edge_step(1'b0, 1'b1, 1'b0, "drain2");

        // error flags
        send_byte(8'h3C, 3'b101, 0);
`ifdef UART_RX_BUFFER_ERROR_STORE_EN
        chk("errflags", 32'(ReadErrors), 32'b101);
`else
        chk("errflags", 32'(ReadErrors), 32'b000);
`endif
        chk("err data", 32'(ReadData), 32'h3C);
        edge_step(1'b0, 1'b1, 1'b0, "errpop");

        // reset during ACK with three entries
        send_byte(8'h11, 3'b000, 0);
        send_byte(8'h22, 3'b000, 0);
        RxData      = 8'h33;
        RxErrors    = 3'b011;
        RxInterrupt = 1'b1;
        for (int i = 0; i < 3; i++) edge_step(i == 2, 1'b0, 1'b0, "pre-rst");
        chk("pre-rst ack", 32'(RxAcknowledge), 1);
        chk("pre-rst cnt", 32'(Count), 3);
        Reset = 1'b0;
        #1;
        mq.delete();
        movf = 1'b0;
        chk("async ack", 32'(RxAcknowledge), 0);
        chk("async cnt", 32'(Count), 0);
        chk("async empty", 32'(Empty), 1);
        chk("async full", 32'(Full), 0);
        repeat (2) @(posedge Clock);
        #1;
        Reset = 1'b1;
        send_byte(8'h33, 3'b011, 0);
        chk("recapture cnt", 32'(Count), 1);
        chk("recapture data", 32'(ReadData), 32'h33);
        edge_step(1'b0, 1'b1, 1'b0, "recap pop");

        // pop on empty, then random traffic across the pointer wrap
        edge_step(1'b0, 1'b1, 1'b0, "empty pop");
        edge_step(1'b0, 1'b1, 1'b0, "empty pop");
        for (int i = 0; i < 20; i++)
            send_byte(8'($urandom), 3'($urandom), 2);
        chk("rand ovf", 32'(Overflow), 0);
        for (int i = 0; i < 40; i++)
            send_byte(8'($urandom), 3'($urandom), 3);
        while (mq.size() > 0) edge_step(1'b0, 1'b1, 1'b0, "final drain");
        edge_step(1'b0, 1'b0, 1'b1, "final clr");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
